xa_bf_out_pack: RTL and testbench

- Responder to the beam forming controller's calculation handshake: accepts one calculation-start pulse together with frame_time, pad_size and end-code request.
- Frames the beam-former result stream as header, P_word_num data words, pad_size zero words, then an optional end code.
- Returns a one-cycle completion pulse, which the controller consumes as its per-calculation end input.
- Sits between the BF arithmetic core and the output DMA/DDR writer; it carries a small skid FIFO to absorb output backpressure.

---
 rtl/xa_bf_out_pack.sv | 210 +++++++++++++++++++++
 tb/tb_xa_bf_out_pack.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xa_bf_out_pack.sv
// Frames one beam-former calculation as header, data words, zero pad and an optional
// end code, with a small skid FIFO between the BF core and the registered output stage.
module xa_bf_out_pack #(
   parameter logic [15:0] P_word_num   = 16'd1024,
   parameter int          P_fifo_depth = 4,
   parameter logic [15:0] P_hdr_mark   = 16'hA5C3,
   parameter logic [63:0] P_end_code   = 64'hFFFF_0000_FFFF_0000
) (
   input  logic        i_clk156m,
   input  logic        i_arst,
   input  logic        i_calc_start,
   input  logic [4:0]  i_frame_time,
   input  logic [19:0] i_pad_size,
   input  logic        i_end_ins,
   input  logic        i_bf_valid,
   input  logic [63:0] i_bf_data,
   output logic        o_bf_ready,
   output logic        o_tx_valid,
   output logic [63:0] o_tx_data,
   input  logic        i_tx_ready,
   output logic        o_sp_end,
   output logic        o_busy,
   output logic        o_err
);

   localparam int              C_aw    = $clog2(P_fifo_depth);
   localparam logic [C_aw:0]   C_depth = (C_aw + 1)'(P_fifo_depth);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_PAD,
      S_ENDC,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [19:0]      pad_size_q;
   logic             end_ins_q;
   logic [15:0]      in_cnt;
   logic [15:0]      out_cnt;
   logic [19:0]      pad_cnt;

   logic [63:0]      fifo_mem [P_fifo_depth];
   logic [C_aw-1:0]  wr_ptr;
   logic [C_aw-1:0]  rd_ptr;
   logic [C_aw:0]    fifo_count;

   logic             tx_xfer;
   logic             tx_free;
   logic             push;
   logic             pop;
   logic             ld_hdr;
   logic             ld_data;
   logic             ld_pad;
   logic             ld_endc;
   logic             drop_valid;

   assign tx_xfer    = o_tx_valid && i_tx_ready;
   assign tx_free    = !o_tx_valid || i_tx_ready;
   assign o_bf_ready = (state == S_DATA) && (fifo_count < C_depth) && (in_cnt < P_word_num);
   assign push       = i_bf_valid && o_bf_ready;
   assign o_sp_end   = (state == S_DONE);
   assign o_busy     = (state != S_IDLE);

   // Each state loads its first output word on the transition into it, so the
   // registered output never needs a separate "already emitted" flag.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      ld_hdr     = 1'b0;
      ld_data    = 1'b0;
      ld_pad     = 1'b0;
      ld_endc    = 1'b0;
      drop_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_calc_start) begin
               state_nxt = S_HDR;
               ld_hdr    = 1'b1;
            end
         end
         S_HDR: begin
            if (tx_xfer) begin
               state_nxt  = S_DATA;
               drop_valid = 1'b1;
            end
         end
         S_DATA: begin
            if (tx_free && (fifo_count != '0)) begin
               ld_data = 1'b1;
               pop     = 1'b1;
            end else if (tx_xfer) begin
               drop_valid = 1'b1;
            end
            if (tx_xfer && (out_cnt == P_word_num - 16'd1)) begin
               if (pad_size_q != 20'd0) begin
                  state_nxt = S_PAD;
                  ld_pad    = 1'b1;
               end else begin
                  state_nxt = S_ENDC;
                  ld_endc   = end_ins_q;
               end
            end
         end
         S_PAD: begin
            if (tx_xfer) begin
               if (pad_cnt < pad_size_q) begin
                  ld_pad = 1'b1;
               end else begin
                  drop_valid = 1'b1;
                  state_nxt  = S_ENDC;
                  ld_endc    = end_ins_q;
               end
            end
         end
         S_ENDC: begin
            if (!end_ins_q) begin
               state_nxt = S_DONE;
            end else if (tx_xfer) begin
               drop_valid = 1'b1;
               state_nxt  = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk156m) begin
      if (i_arst) begin
         state      <= S_IDLE;
         pad_size_q <= '0;
         end_ins_q  <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         pad_cnt    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         o_tx_valid <= 1'b0;
         o_tx_data  <= '0;
         o_err      <= 1'b0;
      end else begin
         state <= state_nxt;
         o_err <= i_calc_start && (state != S_IDLE);

         if (ld_hdr) begin
            pad_size_q <= i_pad_size;
            end_ins_q  <= i_end_ins;
            in_cnt     <= '0;
            out_cnt    <= '0;
            pad_cnt    <= '0;
         end

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            in_cnt <= in_cnt + 16'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase

         if ((state == S_DATA) && tx_xfer) begin
            out_cnt <= out_cnt + 16'd1;
         end

         // Loads come after the drop so a reload in the transfer cycle wins.
         if (drop_valid) begin
            o_tx_valid <= 1'b0;
         end
         if (ld_hdr) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= {P_hdr_mark, 11'b0, i_frame_time, 12'b0, i_pad_size};
         end
         if (ld_data) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= fifo_mem[rd_ptr];
         end
         if (ld_pad) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= '0;
            pad_cnt    <= pad_cnt + 20'd1;
         end
         if (ld_endc) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= P_end_code;
         end
      end
   end

   always_ff @(posedge i_clk156m) begin
      if (push) begin
         fifo_mem[wr_ptr] <= i_bf_data;
      end
   end

endmodule

// File: tb/tb_xa_bf_out_pack.sv
// Directed bench for xa_bf_out_pack: frame contents, backpressure, error pulse,
// reset mid-pad and back-to-back starts on two parameterisations.
module tb_xa_bf_out_pack;

   localparam logic [15:0] C_mark = 16'hA5C3;
   localparam logic [63:0] C_endc = 64'hFFFF_0000_FFFF_0000;

   logic        clk;
   logic        i_arst;
   logic        i_calc_start;
   logic [4:0]  i_frame_time;
   logic [19:0] i_pad_size;
   logic        i_end_ins;
   logic        i_bf_valid;
   logic [63:0] i_bf_data;
   logic        i_tx_ready;
   bit          sel;

   logic        a_bf_ready, a_tx_valid, a_sp_end, a_busy, a_err;
   logic [63:0] a_tx_data;
   logic        b_bf_ready, b_tx_valid, b_sp_end, b_busy, b_err;
   logic [63:0] b_tx_data;

   logic        m_bf_ready, m_tx_valid, m_sp_end, m_busy, m_err;
   logic [63:0] m_tx_data;

   int          n_checks;
   int          n_errors;

   logic [63:0] got_q[$];
   logic [63:0] bf_q[$];
   int          pushed;
   int          data_xfer;
   int          sp_cnt;
   int          err_cnt;
   int          rdy_mode;
   bit          hdr_done;
   bit          stall_prev;
   bit          chk_hdr;
   bit          saw_full;
   logic [63:0] stall_data;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   xa_bf_out_pack #(.P_word_num(16'd4), .P_fifo_depth(4)) u_dut_a (
      .i_clk156m    (clk),
      .i_arst       (i_arst),
      .i_calc_start (i_calc_start & ~sel),
      .i_frame_time (i_frame_time),
      .i_pad_size   (i_pad_size),
      .i_end_ins    (i_end_ins),
      .i_bf_valid   (i_bf_valid & ~sel),
      .i_bf_data    (i_bf_data),
      .o_bf_ready   (a_bf_ready),
      .o_tx_valid   (a_tx_valid),
      .o_tx_data    (a_tx_data),
      .i_tx_ready   (i_tx_ready),
      .o_sp_end     (a_sp_end),
      .o_busy       (a_busy),
      .o_err        (a_err)
   );

   xa_bf_out_pack #(.P_word_num(16'd16), .P_fifo_depth(4)) u_dut_b (
      .i_clk156m    (clk),
      .i_arst       (i_arst),
      .i_calc_start (i_calc_start & sel),
      .i_frame_time (i_frame_time),
      .i_pad_size   (i_pad_size),
      .i_end_ins    (i_end_ins),
      .i_bf_valid   (i_bf_valid & sel),
      .i_bf_data    (i_bf_data),
      .o_bf_ready   (b_bf_ready),
      .o_tx_valid   (b_tx_valid),
      .o_tx_data    (b_tx_data),
      .i_tx_ready   (i_tx_ready),
      .o_sp_end     (b_sp_end),
      .o_busy       (b_busy),
      .o_err        (b_err)
   );

   assign m_bf_ready = sel ? b_bf_ready : a_bf_ready;
   assign m_tx_valid = sel ? b_tx_valid : a_tx_valid;
   assign m_tx_data  = sel ? b_tx_data  : a_tx_data;
   assign m_sp_end   = sel ? b_sp_end   : a_sp_end;
   assign m_busy     = sel ? b_busy     : a_busy;
   assign m_err      = sel ? b_err      : a_err;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Sample at the falling edge, then advance one rising edge and update drivers.
   task automatic tick();
      int   n;
      int   fifo_m;
      logic exp_rdy;
      bit   consumed;
      n        = sel ? 16 : 4;
      consumed = 0;
      @(negedge clk);
      fifo_m  = pushed - data_xfer - ((hdr_done && m_tx_valid) ? 1 : 0);
      exp_rdy = hdr_done && (pushed < n) && (fifo_m < 4);
      if (hdr_done && (pushed < n) && (fifo_m >= 4)) saw_full = 1;
      checkOutput("bf_ready", 64'(m_bf_ready), 64'(exp_rdy));
      if (chk_hdr) begin
         checkOutput("hdr_latency", 64'(m_tx_valid), 64'(1));
         chk_hdr = 0;
      end
      if (stall_prev) begin
         checkOutput("hold_valid", 64'(m_tx_valid), 64'(1));
         checkOutput("hold_data", m_tx_data, stall_data);
      end
      stall_prev = m_tx_valid && !i_tx_ready;
      stall_data = m_tx_data;
      if (m_tx_valid && i_tx_ready) begin
         got_q.push_back(m_tx_data);
         if (!hdr_done) hdr_done = 1;
         else if (data_xfer < n) data_xfer++;
      end
      if (i_bf_valid && m_bf_ready) begin
         pushed++;
         consumed = 1;
      end
      if (m_sp_end) sp_cnt++;
      if (m_err) err_cnt++;
      @(posedge clk);
      #1;
      i_calc_start = 1'b0;
      if (consumed) void'(bf_q.pop_front());
      i_bf_valid = (bf_q.size() > 0);
      i_bf_data  = (bf_q.size() > 0) ? bf_q[0] : 64'h0;
      i_tx_ready = (rdy_mode == 1) ? ~i_tx_ready : 1'b1;
   endtask

   task automatic applyStimulus(input logic [4:0] ft, input logic [19:0] pad, input logic endi);
      i_frame_time = ft;
      i_pad_size   = pad;
      i_end_ins    = endi;
      i_calc_start = 1'b1;
      tick();
      chk_hdr = 1;
   endtask

   task automatic runFrame(input logic [4:0] ft, input logic [19:0] pad, input logic endi,
                           input logic [63:0] base, input int rmode, input bit inject,
                           input bit rst_pad, input bit check_idle);
      int          n;
      int          cyc;
      bit          injected;
      logic [63:0] exp_q[$];
      n        = sel ? 16 : 4;
      cyc      = 0;
      injected = 0;
      exp_q.push_back({C_mark, 11'b0, ft, 12'b0, pad});
      for (int i = 1; i <= n; i++) begin
         exp_q.push_back(base + 64'(i));
         bf_q.push_back(base + 64'(i));
      end
      for (int i = 0; i < int'(pad); i++) exp_q.push_back(64'h0);
      if (endi) exp_q.push_back(C_endc);
      rdy_mode   = rmode;
      i_tx_ready = 1'b1;
      got_q.delete();
      hdr_done  = 0;
      pushed    = 0;
      data_xfer = 0;
      sp_cnt    = 0;
      err_cnt   = 0;
      saw_full  = 0;
      applyStimulus(ft, pad, endi);
      while ((sp_cnt == 0) && (cyc < 400)) begin
         if (inject && !injected && hdr_done && (data_xfer == 1)) begin
            i_calc_start = 1'b1;
            i_frame_time = 5'h1F;
            i_pad_size   = 20'd9;
            injected     = 1;
         end
         if (rst_pad && (data_xfer == n) && (got_q.size() >= n + 3)) begin
            i_arst = 1'b1;
            tick();
            i_arst     = 1'b0;
            stall_prev = 0;
            @(negedge clk);
            checkOutput("rst_tx_valid", 64'(m_tx_valid), 64'(0));
            checkOutput("rst_tx_data", m_tx_data, 64'h0);
            checkOutput("rst_bf_ready", 64'(m_bf_ready), 64'(0));
            checkOutput("rst_sp_end", 64'(m_sp_end), 64'(0));
            checkOutput("rst_busy", 64'(m_busy), 64'(0));
            checkOutput("rst_err", 64'(m_err), 64'(0));
            checkOutput("rst_no_sp_end", 64'(sp_cnt), 64'(0));
            @(posedge clk);
            #1;
            bf_q.delete();
            i_bf_valid = 1'b0;
            hdr_done   = 0;
            pushed     = 0;
            data_xfer  = 0;
            return;
         end
         tick();
         cyc++;
      end
      checkOutput("nwords", 64'(got_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < got_q.size()) checkOutput($sformatf("word%0d", i), got_q[i], exp_q[i]);
      end
      checkOutput("sp_end_cnt", 64'(sp_cnt), 64'(1));
      checkOutput("err_cnt", 64'(err_cnt), inject ? 64'(1) : 64'(0));
      if (check_idle) begin
         @(negedge clk);
         checkOutput("busy_after", 64'(m_busy), 64'(0));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      sel          = 0;
      i_arst       = 1'b1;
      i_calc_start = 1'b0;
      i_frame_time = '0;
      i_pad_size   = '0;
      i_end_ins    = 1'b0;
      i_bf_valid   = 1'b0;
      i_bf_data    = '0;
      i_tx_ready   = 1'b1;
      rdy_mode     = 0;
      repeat (2) @(posedge clk);
      #1;
      i_arst = 1'b0;
      @(negedge clk);
      checkOutput("reset_tx_valid", 64'(a_tx_valid), 64'(0));
      checkOutput("reset_tx_data", a_tx_data, 64'h0);
      checkOutput("reset_bf_ready", 64'(a_bf_ready), 64'(0));
      checkOutput("reset_sp_end", 64'(a_sp_end), 64'(0));
      checkOutput("reset_busy", 64'(a_busy), 64'(0));
      checkOutput("reset_err", 64'(a_err), 64'(0));
      @(posedge clk);
      #1;

      $display("[TB] basic frame, no pad, no end code");
      runFrame(5'h13, 20'd0, 1'b0, 64'h0, 0, 0, 0, 1);

      $display("[TB] pad 3 with end code");
      runFrame(5'h02, 20'd3, 1'b1, 64'h10, 0, 0, 0, 1);

      $display("[TB] backpressure with toggling ready");
      sel = 1;
      runFrame(5'h07, 20'd1, 1'b1, 64'h100, 1, 0, 0, 1);
      checkOutput("bf_ready_dropped", 64'(saw_full), 64'(1));
      sel = 0;

      $display("[TB] calc_start during data");
      runFrame(5'h0A, 20'd2, 1'b0, 64'h200, 0, 1, 0, 1);

      $display("[TB] reset during pad");
      runFrame(5'h05, 20'd20, 1'b1, 64'h300, 0, 0, 1, 0);

      $display("[TB] clean frame then back-to-back start");
      runFrame(5'h1C, 20'd1, 1'b0, 64'h400, 0, 0, 0, 0);
      runFrame(5'h03, 20'd0, 1'b1, 64'h500, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
